// File: rtl/hwpe_stream_job_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hwpe_job_ctrl_package
//
// Shared definitions for the HWPE stream job sequencer:
//   - job_state_e     : sequencer state encoding
//   - JOB_ADDR_WIDTH  : default streamer base-address width
//   - JOB_ITER_WIDTH  : default iteration counter width
//   - JOB_REG_*       : control-slave register indices for the job fields
//
// Optional feature macro used by the files importing this package:
//   HWPE_JOB_CTRL_WATCHDOG_EN
// -----------------------------------------------------------------------------
package hwpe_job_ctrl_package;

    localparam int unsigned JOB_ADDR_WIDTH = 32;
    localparam int unsigned JOB_ITER_WIDTH = 16;

    // Control-slave register map. Base addresses and strides occupy one
    // register per stream; room is reserved for the maximum of 12 streams.
    localparam int unsigned JOB_MAX_STREAMS    = 12;
    localparam int unsigned JOB_REG_N_ITER     = 0;
    localparam int unsigned JOB_REG_TIMEOUT    = 1;
    localparam int unsigned JOB_REG_BASE_ADDR  = 2;
    localparam int unsigned JOB_REG_STRIDE     = JOB_REG_BASE_ADDR + JOB_MAX_STREAMS;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_RUN   = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } job_state_e;

endpackage

// File: rtl/hwpe_stream_job_ctrl_done_tracker.sv
// -----------------------------------------------------------------------------
// hwpe_job_done_tracker
//
// One sticky done bit per stream. Bits are set by done pulses while set_en_i
// is high; clr_i restarts tracking for a new iteration. all_done_o already
// includes the pulses of the current cycle, so the last pulse is seen without
// waiting for it to be registered.
//
// Ports:
//   clk_i       in   clock
//   rst_i       in   synchronous active-high reset
//   clr_i       in   clear all sticky bits (pulses of this cycle still land)
//   set_en_i    in   accept done pulses this cycle
//   set_i       in   NB_STREAMS done pulses
//   all_done_o  out  every stream has completed (sticky OR current pulse)
// -----------------------------------------------------------------------------
module hwpe_job_done_tracker #(
    parameter int unsigned NB_STREAMS = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic                  set_en_i,
    input  logic [NB_STREAMS-1:0] set_i,
    output logic                  all_done_o
);

    logic [NB_STREAMS-1:0] w_bit_done;

    generate
        for (genvar gi = 0; gi < NB_STREAMS; gi++) begin : g_bit
            logic r_done;
            logic w_set;

            assign w_set = set_en_i & set_i[gi];

            // A pulse in the clearing cycle wins over the clear, so a stream
            // that finishes immediately after its start is not lost.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_done <= 1'b0;
                end else if (clr_i) begin
                    r_done <= w_set;
                end else begin
                    r_done <= r_done | w_set;
                end
            end

            assign w_bit_done[gi] = r_done | w_set;
        end
    endgenerate

    assign all_done_o = &w_bit_done;

endmodule

// File: rtl/hwpe_stream_job_ctrl.sv
// -----------------------------------------------------------------------------
// hwpe_stream_job_ctrl
//
// Job sequencer between the HWPE control slave and the source/sink streamers.
// A job is a number of iterations; each iteration starts every stream, waits
// for every stream to report done, then advances all base addresses by their
// stride. Stream index order is sources first, then sinks.
//
// Optional feature: define HWPE_JOB_CTRL_WATCHDOG_EN to add a RUN-phase
// watchdog (timeout_i / timeout_o).
//
// Ports:
//   clk_i          in   clock
//   rst_i          in   synchronous active-high reset
//   start_i        in   one-cycle job start (honoured in IDLE only)
//   n_iter_i       in   iteration count, 0 runs one iteration
//   base_addr_i    in   initial base address per stream
//   iter_stride_i  in   per-iteration address increment per stream
//   src_done_i     in   done pulses from source streamers
//   snk_done_i     in   done pulses from sink streamers
//   timeout_i      in   RUN cycle limit, 0 disables (watchdog build only)
//   req_start_o    out  start pulse per stream
//   base_addr_o    out  current base address per stream
//   iter_cnt_o     out  completed-iteration count
//   busy_o         out  job in progress
//   evt_o          out  one-cycle pulse per completed iteration
//   done_o         out  one-cycle pulse at job end
//   timeout_o      out  job ended by watchdog, sticky (watchdog build only)
// -----------------------------------------------------------------------------
module hwpe_stream_job_ctrl
    import hwpe_job_ctrl_package::*;
#(
    parameter int unsigned NB_OPERANDS = 2,
    parameter int unsigned NB_RESULTS  = 1,
    parameter int unsigned ADDR_WIDTH  = JOB_ADDR_WIDTH,
    parameter int unsigned ITER_WIDTH  = JOB_ITER_WIDTH,
    localparam int unsigned NB_STREAMS = NB_OPERANDS + NB_RESULTS
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             start_i,
    input  logic [ITER_WIDTH-1:0]            n_iter_i,
    input  logic [NB_STREAMS*ADDR_WIDTH-1:0] base_addr_i,
    input  logic [NB_STREAMS*ADDR_WIDTH-1:0] iter_stride_i,
    input  logic [NB_OPERANDS-1:0]           src_done_i,
    input  logic [NB_RESULTS-1:0]            snk_done_i,
`ifdef HWPE_JOB_CTRL_WATCHDOG_EN
    input  logic [31:0]                      timeout_i,
    output logic                             timeout_o,
`endif
    output logic [NB_STREAMS-1:0]            req_start_o,
    output logic [NB_STREAMS*ADDR_WIDTH-1:0] base_addr_o,
    output logic [ITER_WIDTH-1:0]            iter_cnt_o,
    output logic                             busy_o,
    output logic                             evt_o,
    output logic                             done_o
);

    job_state_e            r_state;
    job_state_e            w_state_next;

    logic [ITER_WIDTH-1:0] r_n_iter;
    logic [ITER_WIDTH-1:0] r_iter_cnt;
    logic [ITER_WIDTH-1:0] w_iter_inc;

    logic                  w_take_job;
    logic                  w_last_iter;
    logic                  w_in_start;
    logic                  w_in_run;
    logic                  w_all_done;
    logic [NB_STREAMS-1:0] w_done_pulse;
    logic                  w_wd_expire;

    assign w_take_job   = (r_state == ST_IDLE) && start_i;
    assign w_in_start   = (r_state == ST_START);
    assign w_in_run     = (r_state == ST_RUN);
    assign w_iter_inc   = r_iter_cnt + ITER_WIDTH'(1);
    assign w_last_iter  = (w_iter_inc == r_n_iter);
    assign w_done_pulse = {snk_done_i, src_done_i};

    // ------------------------------------------------------------------
    // Per-stream base-address registers
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NB_STREAMS; gi++) begin : g_stream
            logic [ADDR_WIDTH-1:0] r_base_lat;
            logic [ADDR_WIDTH-1:0] r_stride_lat;
            logic [ADDR_WIDTH-1:0] r_base_addr;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_base_lat   <= '0;
                    r_stride_lat <= '0;
                    r_base_addr  <= '0;
                end else begin
                    // The job descriptor is captured once, so the slave may
                    // reprogram its registers while the job is running.
                    if (w_take_job) begin
                        r_base_lat   <= base_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
                        r_stride_lat <= iter_stride_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
                    end
                    if (r_state == ST_LOAD) begin
                        r_base_addr <= r_base_lat;
                    end else if ((r_state == ST_NEXT) && !w_last_iter) begin
                        // Natural modulo-2^ADDR_WIDTH wrap.
                        r_base_addr <= r_base_addr + r_stride_lat;
                    end
                end
            end

            assign base_addr_o[gi*ADDR_WIDTH +: ADDR_WIDTH] = r_base_addr;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Done tracking
    // ------------------------------------------------------------------
    hwpe_job_done_tracker #(
        .NB_STREAMS (NB_STREAMS)
    ) i_done_tracker (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (w_in_start),
        .set_en_i   (w_in_start | w_in_run),
        .set_i      (w_done_pulse),
        .all_done_o (w_all_done)
    );

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
`ifdef HWPE_JOB_CTRL_WATCHDOG_EN
    logic [31:0] r_timeout_lim;
    logic [31:0] r_wd_cnt;
    logic        r_timeout;

    // Expires in the RUN cycle in which the running count reaches the limit.
    assign w_wd_expire = w_in_run && (r_timeout_lim != 32'd0) &&
                         ((r_wd_cnt + 32'd1) == r_timeout_lim);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_timeout_lim <= '0;
            r_wd_cnt      <= '0;
            r_timeout     <= 1'b0;
        end else begin
            if (w_take_job) begin
                r_timeout_lim <= timeout_i;
            end
            if (w_in_start) begin
                r_wd_cnt <= '0;
            end else if (w_in_run) begin
                r_wd_cnt <= r_wd_cnt + 32'd1;
            end
            if (r_state == ST_LOAD) begin
                r_timeout <= 1'b0;
            end else if (w_wd_expire && !w_all_done) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout_o = r_timeout;
`else
    assign w_wd_expire = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Sequencer: state register and job counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_n_iter   <= '0;
            r_iter_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_take_job) begin
                r_n_iter <= (n_iter_i == '0) ? ITER_WIDTH'(1) : n_iter_i;
            end
            if (r_state == ST_LOAD) begin
                r_iter_cnt <= '0;
            end else if (r_state == ST_NEXT) begin
                r_iter_cnt <= w_iter_inc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start_i) w_state_next = ST_LOAD;
            ST_LOAD:  w_state_next = ST_START;
            ST_START: w_state_next = ST_RUN;
            ST_RUN: begin
                // A completed iteration takes precedence over a watchdog
                // expiring in the very same cycle.
                if (w_all_done) begin
                    w_state_next = ST_NEXT;
                end else if (w_wd_expire) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_NEXT:  w_state_next = w_last_iter ? ST_DONE : ST_START;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    assign req_start_o = {NB_STREAMS{w_in_start}};
    assign iter_cnt_o  = r_iter_cnt;
    assign busy_o      = (r_state != ST_IDLE);
    assign evt_o       = (r_state == ST_NEXT);
    assign done_o      = (r_state == ST_DONE);

endmodule

// File: tb/tb_hwpe_stream_job_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hwpe_stream_job_ctrl
//
// Job-level bench for hwpe_stream_job_ctrl (2 sources, 1 sink, 32-bit
// addresses). Each job record holds the descriptor, the done-pulse timing and
// the expected final iteration count / sink base address. The reference is an
// arithmetic timeline: iteration i starts at cycle 2 + i*(L+2), where L is the
// cycle offset of the last done pulse (at least 1), evt follows at +L+1 and
// done_o arrives at 2 + n*(L+2). Define HWPE_JOB_CTRL_WATCHDOG_EN to also run
// the watchdog sequence.
// -----------------------------------------------------------------------------
module tb_hwpe_stream_job_ctrl;

    typedef struct packed {
        logic [15:0]      n_iter;
        logic [2:0][31:0] base;
        logic [2:0][31:0] stride;
        logic [2:0][7:0]  dly;
        logic             dup;
        logic             start_in_run;
        logic             load_pulse;
        logic [7:0]       abort_at;
        logic [15:0]      exp_iter;
        logic [31:0]      exp_sink;
    } job_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [15:0] n_iter_i;
    logic [95:0] base_addr_i;
    logic [95:0] iter_stride_i;
    logic [1:0]  src_done_i;
    logic [0:0]  snk_done_i;
    logic [2:0]  req_start_o;
    logic [95:0] base_addr_o;
    logic [15:0] iter_cnt_o;
    logic        busy_o;
    logic        evt_o;
    logic        done_o;
`ifdef HWPE_JOB_CTRL_WATCHDOG_EN
    logic [31:0] timeout_i;
    logic        timeout_o;
`endif

    always #5 clk = ~clk;

    hwpe_stream_job_ctrl #(
        .NB_OPERANDS (2),
        .NB_RESULTS  (1),
        .ADDR_WIDTH  (32),
        .ITER_WIDTH  (16)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .n_iter_i      (n_iter_i),
        .base_addr_i   (base_addr_i),
        .iter_stride_i (iter_stride_i),
        .src_done_i    (src_done_i),
        .snk_done_i    (snk_done_i),
`ifdef HWPE_JOB_CTRL_WATCHDOG_EN
        .timeout_i     (timeout_i),
        .timeout_o     (timeout_o),
`endif
        .req_start_o   (req_start_o),
        .base_addr_o   (base_addr_o),
        .iter_cnt_o    (iter_cnt_o),
        .busy_o        (busy_o),
        .evt_o         (evt_o),
        .done_o        (done_o)
    );

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [15:0] prev_iter;
    logic [95:0] prev_base;
    logic        prev_to;
    job_t        jobs[$];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic job_t mk(input logic [15:0] n, input logic [95:0] b, input logic [95:0] s,
                                input logic [23:0] d, input logic dup, input logic sir,
                                input logic lp, input logic [7:0] ab,
                                input logic [15:0] ei, input logic [31:0] es);
        job_t j;
        j.n_iter = n; j.base = b; j.stride = s; j.dly = d;
        j.dup = dup; j.start_in_run = sir; j.load_pulse = lp; j.abort_at = ab;
        j.exp_iter = ei; j.exp_sink = es;
        return j;
    endfunction

    // Expected base of every stream after bi completed advances.
    function automatic logic [95:0] base_after(input job_t j, input int bi);
        logic [95:0] r;
        for (int k = 0; k < 3; k++) begin
            r[k*32 +: 32] = j.base[k] + 32'(bi) * j.stride[k];
        end
        return r;
    endfunction

    task automatic check_idle_zero(input string tag);
        chk({tag, "_req"},  96'(req_start_o), 96'(0));
        chk({tag, "_busy"}, 96'(busy_o),      96'(0));
        chk({tag, "_evt"},  96'(evt_o),       96'(0));
        chk({tag, "_done"}, 96'(done_o),      96'(0));
        chk({tag, "_iter"}, 96'(iter_cnt_o),  96'(0));
        chk({tag, "_base"}, base_addr_o,      96'(0));
`ifdef HWPE_JOB_CTRL_WATCHDOG_EN
        chk({tag, "_tmo"},  96'(timeout_o),   96'(0));
`endif
    endtask

    task automatic run_job(input int idx, input job_t j);
        int n, lastd, per, done_c, last_c, evts, o, it, bi;
        logic [2:0] pulses;
        logic       exp_req, exp_evt;
        n = (j.n_iter == 16'd0) ? 1 : int'(j.n_iter);
        lastd = 1;
        for (int k = 0; k < 3; k++) if (int'(j.dly[k]) > lastd) lastd = int'(j.dly[k]);
        per    = lastd + 2;
        done_c = 2 + n * per;
        last_c = (j.abort_at != 8'd0) ? int'(j.abort_at) : done_c + 1;
        evts   = 0;
        for (int c = 0; c <= last_c; c++) begin
            if (c == 0) begin
                n_iter_i = j.n_iter; base_addr_i = j.base; iter_stride_i = j.stride;
`ifdef HWPE_JOB_CTRL_WATCHDOG_EN
                timeout_i = 32'd0;
`endif
                start_i = 1'b1;
            end else begin
                start_i = j.start_in_run && (c == 3);
                if (c == 1) begin
                    n_iter_i = 16'($urandom);
                    base_addr_i = {$urandom, $urandom, $urandom};
                    iter_stride_i = {$urandom, $urandom, $urandom};
`ifdef HWPE_JOB_CTRL_WATCHDOG_EN
                    timeout_i = $urandom_range(1, 3);
`endif
                end
            end
            o  = (c >= 2) ? (c - 2) % per : 0;
            it = (c >= 2) ? (c - 2) / per : n;
            pulses = 3'b000;
            if (it < n) begin
                for (int k = 0; k < 3; k++) begin
                    if (o == int'(j.dly[k])) pulses[k] = 1'b1;
                    if (j.dup && o == ((int'(j.dly[k]) + 1 < lastd) ? int'(j.dly[k]) + 1 : lastd))
                        pulses[k] = 1'b1;
                end
            end
            if (j.load_pulse && c == 1) pulses = 3'b111;
            src_done_i = pulses[1:0];
            snk_done_i = pulses[2:2];
            rst_i = (j.abort_at != 8'd0) && (c == int'(j.abort_at));
            @(negedge clk);
            exp_req = (it < n) && (o == 0);
            exp_evt = (it < n) && (o == lastd + 1);
            bi = (evts < n - 1) ? evts : n - 1;
            chk("req_start", 96'(req_start_o), 96'({3{exp_req}}));
            chk("evt",       96'(evt_o),       96'(exp_evt));
            chk("done",      96'(done_o),      96'(c == done_c));
            chk("busy",      96'(busy_o),      96'(c >= 1 && c <= done_c));
            chk("iter_cnt",  96'(iter_cnt_o),  (c < 2) ? 96'(prev_iter) : 96'(evts));
            chk("base_addr", base_addr_o,      (c < 2) ? prev_base : base_after(j, bi));
`ifdef HWPE_JOB_CTRL_WATCHDOG_EN
            chk("timeout",   96'(timeout_o),   (c < 2) ? 96'(prev_to) : 96'(0));
`endif
            if (exp_evt) evts++;
            @(posedge clk); #1;
        end
        start_i = 1'b0; src_done_i = '0; snk_done_i = '0;
        if (j.abort_at != 8'd0) begin
            rst_i = 1'b0;
            check_idle_zero("abort");
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                chk("abort_no_done", 96'(done_o), 96'(0));
                chk("abort_no_busy", 96'(busy_o), 96'(0));
                @(posedge clk); #1;
            end
            prev_iter = '0; prev_base = '0;
        end else begin
            prev_iter = 16'(n); prev_base = base_after(j, n - 1);
        end
        prev_to = 1'b0;
        chk("final_iter", 96'(iter_cnt_o), 96'(j.exp_iter));
        chk("final_sink_base", 96'(base_addr_o[95:64]), 96'(j.exp_sink));
        $display("job %0d: n_iter=%0d dly=%0d/%0d/%0d abort=%0d iter_cnt=%0d sink_base=%08h",
                 idx, j.n_iter, j.dly[0], j.dly[1], j.dly[2], j.abort_at, iter_cnt_o,
                 base_addr_o[95:64]);
    endtask

`ifdef HWPE_JOB_CTRL_WATCHDOG_EN
    // Sink never reports done: the job ends after 50 RUN cycles with timeout.
    task automatic run_watchdog();
        logic [95:0] b;
        b = {32'h300, 32'h200, 32'h100};
        for (int c = 0; c <= 55; c++) begin
            start_i = (c == 0);
            if (c == 0) begin
                n_iter_i = 16'd2; base_addr_i = b; iter_stride_i = {3{32'h40}}; timeout_i = 32'd50;
            end
            src_done_i = (c == 4) ? 2'b11 : 2'b00;
            snk_done_i = 1'b0;
            @(negedge clk);
            chk("wd_req",  96'(req_start_o), (c == 2) ? 96'(3'b111) : 96'(0));
            chk("wd_done", 96'(done_o),      96'(c == 53));
            chk("wd_tmo",  96'(timeout_o),   (c < 2) ? 96'(prev_to) : 96'(c >= 53));
            chk("wd_busy", 96'(busy_o),      96'(c >= 1 && c <= 53));
            chk("wd_evt",  96'(evt_o),       96'(0));
            @(posedge clk); #1;
        end
        chk("wd_iter", 96'(iter_cnt_o), 96'(0));
        chk("wd_base", base_addr_o, b);
        prev_iter = '0; prev_base = b; prev_to = 1'b1;
        $display("watchdog job: timeout_o=%0d iter_cnt=%0d", timeout_o, iter_cnt_o);
    endtask
`endif

    initial begin
        logic [95:0] b0;
        logic [95:0] s0;
        b0 = {32'h300, 32'h200, 32'h100};
        s0 = {32'h20, 32'h40, 32'h40};

        // Directed rows: {n, base, stride, dly(sink,src1,src0), dup, start_in_run,
        //                 load_pulse, abort_at, exp_iter, exp_sink}
        jobs.push_back(mk(16'd1, b0, s0, {8'd5, 8'd5, 8'd5},   0, 0, 0, 8'd0,  16'd1, 32'h300));
        jobs.push_back(mk(16'd3, b0, s0, {8'd2, 8'd4, 8'd3},   0, 0, 0, 8'd0,  16'd3, 32'h340));
        jobs.push_back(mk(16'd1, b0, s0, {8'd2, 8'd3, 8'd13},  1, 0, 0, 8'd0,  16'd1, 32'h300));
        jobs.push_back(mk(16'd0, b0, s0, {8'd4, 8'd4, 8'd4},   0, 1, 0, 8'd0,  16'd1, 32'h300));
        jobs.push_back(mk(16'd2, {3{32'hFFFF_FFF0}}, {3{32'h20}}, {8'd2, 8'd1, 8'd3},
                          0, 0, 0, 8'd0, 16'd2, 32'h0000_0010));
        jobs.push_back(mk(16'd2, b0, s0, {8'd0, 8'd0, 8'd0},   0, 0, 1, 8'd0,  16'd2, 32'h320));
        jobs.push_back(mk(16'd3, b0, s0, {8'd4, 8'd4, 8'd4},   0, 0, 0, 8'd10, 16'd0, 32'h0));
        jobs.push_back(mk(16'd2, b0, s0, {8'd1, 8'd6, 8'd2},   1, 1, 1, 8'd0,  16'd2, 32'h320));
        for (int r = 0; r < 10; r++) begin
            logic [15:0] n;
            logic [15:0] ne;
            logic [95:0] b;
            logic [95:0] s;
            logic [23:0] d;
            n  = 16'($urandom_range(0, 4));
            ne = (n == 16'd0) ? 16'd1 : n;
            b  = {$urandom, $urandom, $urandom};
            s  = {$urandom, $urandom, $urandom};
            d  = {8'($urandom_range(0, 8)), 8'($urandom_range(0, 8)), 8'($urandom_range(0, 8))};
            jobs.push_back(mk(n, b, s, d, 1'($urandom), 1'($urandom), 1'($urandom), 8'd0, ne,
                              b[95:64] + 32'(ne - 16'd1) * s[95:64]));
        end

        rst_i = 1'b1; start_i = 1'b0; n_iter_i = '0; base_addr_i = '0; iter_stride_i = '0;
        src_done_i = '0; snk_done_i = '0;
`ifdef HWPE_JOB_CTRL_WATCHDOG_EN
        timeout_i = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        check_idle_zero("reset");
        @(posedge clk); #1;
        prev_iter = '0; prev_base = '0; prev_to = 1'b0;

        foreach (jobs[i]) run_job(i, jobs[i]);
`ifdef HWPE_JOB_CTRL_WATCHDOG_EN
        run_watchdog();
        run_job(99, jobs[0]);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
